// File: rtl/pending_encoder_if.sv
// Offer handshake between the pending encoder (master) and the event consumer (slave).
interface pending_encoder_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N);

  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_ready;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/pending_encoder.sv
// Registered N-to-log2(N) request encoder: sticky pending capture, one index offered per
// valid/ready handshake, fixed (highest wins) or round-robin priority.
module pending_encoder #(
  parameter int N  = 4,
  parameter int RR = 0,
  localparam int W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_in,
  input  logic                clr,
  pending_encoder_if.master   bus,
  output logic [N-1:0]        pending,
  output logic                overflow
);

  logic         valid_q;
  logic [W-1:0] idx_q;
  logic [W-1:0] ptr;
  logic         accept;
  logic         load;
  logic [N-1:0] src;
  logic [W-1:0] base_ptr;
  logic [W-1:0] sel;
  logic         found;
  int           cand;

  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;

  assign accept = valid_q & bus.out_ready;
  assign load   = ~valid_q | accept;
  assign src    = pending | req_in;

  // The round-robin search starts after the index being retired this cycle, so the
  // pointer update and the next selection take effect on the same edge.
  assign base_ptr = accept ? idx_q : ptr;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = 0;
    if (RR != 0) begin
      for (int k = 0; k < N; k++) begin
        cand = int'(base_ptr) + 1 + k;
        if (cand >= N) cand = cand - N;
        if (!found && src[W'(cand)]) begin
          found = 1'b1;
          sel   = W'(cand);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (src[i]) begin
          found = 1'b1;
          sel   = W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      overflow <= 1'b0;
      ptr      <= W'(N - 1);
    end else if (clr) begin
      pending  <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= |(req_in & pending);
      if (accept && (RR != 0)) ptr <= idx_q;
      if (load) begin
        if (found) begin
          valid_q <= 1'b1;
          idx_q   <= sel;
          pending <= src & ~({{(N-1){1'b0}}, 1'b1} << sel);
        end else begin
          valid_q <= 1'b0;
          pending <= src;
        end
      end else begin
        pending <= src;
      end
    end
  end

endmodule

// File: tb/tb_pending_encoder.sv
// Bench for pending_encoder: directed table and sequences on N=4 instances, then random
// stimulus on fixed, round-robin N=4 and round-robin N=6 instances against a reference model.
module tb_pending_encoder;
  localparam int N  = 4;
  localparam int N6 = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_in = '0;
  logic [N6-1:0] req6 = '0;
  logic          clr = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  pend_f, pend_r;
  logic [N6-1:0] pend_6;
  logic          ovf_f, ovf_r, ovf_6;

  int tests = 0;
  int fails = 0;
  bit rand_phase = 0;

  pending_encoder_if #(.N(N))  bus_f ();
  pending_encoder_if #(.N(N))  bus_r ();
  pending_encoder_if #(.N(N6)) bus_6 ();

  assign bus_f.out_ready = out_ready;
  assign bus_r.out_ready = out_ready;
  assign bus_6.out_ready = out_ready;

  pending_encoder #(.N(N), .RR(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr),
    .bus(bus_f), .pending(pend_f), .overflow(ovf_f));

  pending_encoder #(.N(N), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr),
    .bus(bus_r), .pending(pend_r), .overflow(ovf_r));

  pending_encoder #(.N(N6), .RR(1)) u_rr6 (
    .clk(clk), .rst_n(rst_n), .req_in(req6), .clr(clr),
    .bus(bus_6), .pending(pend_6), .overflow(ovf_6));

  always #5 clk = ~clk;

  // Reference model: one entry per instance, written from the behavioural rules.
  int        m_n[3]  = '{4, 4, 6};
  bit        m_rr[3] = '{0, 1, 1};
  bit [63:0] m_pend[3];
  bit        m_v[3];
  int        m_idx[3];
  int        m_ptr[3];
  bit        m_ovf[3];

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = '0;
      m_v[k]    = 0;
      m_idx[k]  = 0;
      m_ptr[k]  = m_n[k] - 1;
      m_ovf[k]  = 0;
    end
  endtask

  task automatic m_step(input int k, input bit [63:0] req, input bit c, input bit rdy);
    bit [63:0] src;
    bit        acc;
    int        sel;
    if (c) begin
      m_pend[k] = '0;
      m_v[k]    = 0;
      m_ovf[k]  = 0;
      return;
    end
    m_ovf[k] = (req & m_pend[k]) != 0;
    acc = m_v[k] && rdy;
    if (acc && m_rr[k]) m_ptr[k] = m_idx[k];
    if (!m_v[k] || acc) begin
      src = m_pend[k] | req;
      sel = -1;
      if (m_rr[k]) begin
        for (int d = 1; d <= m_n[k]; d++) begin
          int j;
          j = (m_ptr[k] + d) % m_n[k];
          if (sel < 0 && src[j]) sel = j;
        end
      end else begin
        for (int j = m_n[k] - 1; j >= 0; j--)
          if (sel < 0 && src[j]) sel = j;
      end
      if (sel < 0) m_v[k] = 0;
      else begin
        m_v[k]   = 1;
        m_idx[k] = sel;
        src[sel] = 1'b0;
      end
      m_pend[k] = src;
    end else begin
      m_pend[k] = m_pend[k] | req;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_models();
    chk("fix_valid", 64'(bus_f.out_valid), 64'(m_v[0]));
    chk("fix_idx",   64'(bus_f.out_idx),   64'(m_idx[0]));
    chk("fix_pend",  64'(pend_f),          m_pend[0]);
    chk("fix_ovf",   64'(ovf_f),           64'(m_ovf[0]));
    chk("rr_valid",  64'(bus_r.out_valid), 64'(m_v[1]));
    chk("rr_idx",    64'(bus_r.out_idx),   64'(m_idx[1]));
    chk("rr_pend",   64'(pend_r),          m_pend[1]);
    chk("rr_ovf",    64'(ovf_r),           64'(m_ovf[1]));
    chk("rr6_valid", 64'(bus_6.out_valid), 64'(m_v[2]));
    chk("rr6_idx",   64'(bus_6.out_idx),   64'(m_idx[2]));
    chk("rr6_pend",  64'(pend_6),          m_pend[2]);
    chk("rr6_ovf",   64'(ovf_6),           64'(m_ovf[2]));
    if (bus_6.out_valid && int'(bus_6.out_idx) >= N6)
      chk("rr6_idx_range", 64'(bus_6.out_idx), 64'(N6 - 1));
  endtask

  // One clock: inputs already set; models advance with the same inputs; sample #1 later.
  task automatic step();
    @(posedge clk);
    m_step(0, 64'(req_in), clr, out_ready);
    m_step(1, 64'(req_in), clr, out_ready);
    m_step(2, 64'(req6), clr, out_ready);
    #1;
    if (rand_phase) cmp_models();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] idx;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // fixed priority burst
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 2'd3, 4'b0010, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0});
    // backpressure
    tbl.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0});
    tbl.push_back('{4'b1000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0});
    // overflow on repeated bit2
    tbl.push_back('{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0});
    tbl.push_back('{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0});
    tbl.push_back('{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1});
    tbl.push_back('{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0});
    // accept and re-request the same index together
    tbl.push_back('{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0});

    do_reset();
    chk("reset_valid", 64'(bus_f.out_valid), 64'd0);
    chk("reset_pend",  64'(pend_f), 64'd0);

    foreach (tbl[i]) begin
      req_in    = tbl[i].req;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(bus_f.out_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_idx", i),   64'(bus_f.out_idx),   64'(tbl[i].idx));
      chk($sformatf("tbl%0d_pend", i),  64'(pend_f),          64'(tbl[i].pend));
      chk($sformatf("tbl%0d_ovf", i),   64'(ovf_f),           64'(tbl[i].ovf));
    end
    req_in = '0;

    // async reset mid-offer
    do_reset();
    out_ready = 1'b0;
    req_in = 4'b0100; step();
    req_in = 4'b0110; step();
    req_in = 4'b0000;
    chk("pre_rst_pend",  64'(pend_f), 64'h6);
    chk("pre_rst_valid", 64'(bus_f.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_valid", 64'(bus_f.out_valid), 64'd0);
    chk("async_rst_idx",   64'(bus_f.out_idx), 64'd0);
    chk("async_rst_pend",  64'(pend_f), 64'd0);
    chk("async_rst_ovf",   64'(ovf_f), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_idle", 64'(bus_f.out_valid), 64'd0);

    // round-robin rotation with a stall on index 2
    do_reset();
    req_in = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rr_seq%0d", i), 64'(bus_r.out_idx), 64'(i % 4));
      chk($sformatf("rr_seq%0d_v", i), 64'(bus_r.out_valid), 64'd1);
    end
    step();
    chk("rr_at2", 64'(bus_r.out_idx), 64'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rr_stall%0d", i), 64'(bus_r.out_idx), 64'd2);
    end
    out_ready = 1'b1;
    step();
    chk("rr_resume", 64'(bus_r.out_idx), 64'd3);
    req_in = '0;

    // clr discards pending and a simultaneous request
    do_reset();
    out_ready = 1'b0;
    req_in = 4'b0100; step();
    req_in = 4'b1011; step();
    chk("pre_clr_pend", 64'(pend_f), 64'hB);
    req_in = 4'b0100;
    clr = 1'b1;
    step();
    chk("clr_valid", 64'(bus_f.out_valid), 64'd0);
    chk("clr_pend",  64'(pend_f), 64'd0);
    clr = 1'b0;
    req_in = '0;
    out_ready = 1'b1;
    step();
    chk("clr_lost_valid", 64'(bus_f.out_valid), 64'd0);
    chk("clr_lost_pend",  64'(pend_f), 64'd0);

    // random stimulus against the model on all three instances
    do_reset();
    rand_phase = 1;
    for (int i = 0; i < 600; i++) begin
      req_in    = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req6      = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      clr       = ($urandom_range(0, 29) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    rand_phase = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
